// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload and a parity bit, one bit per clock,
// followed by a programmable idle gap before the next frame can be accepted.
module serial_frame_tx #(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        PRE_LEN    = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE   = 4'b1010,
  parameter bit                 PARITY_ODD = 1'b0,
  parameter int unsigned        GAP        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              done
);

  localparam int unsigned CntMax0 = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int unsigned CntMax  = (GAP > CntMax0) ? GAP : CntMax0;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  // The counter holds the number of bits still to send in the current section.
  localparam logic [CntW-1:0] PreLast  = CntW'(PRE_LEN - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StData,
    StPar,
    StGap
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [PRE_LEN-1:0]  pre_q;
  logic [DATA_W-1:0]   data_q;
  logic                par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pre_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      ready      <= 1'b1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_q     <= data_in;
            par_q      <= (^data_in) ^ PARITY_ODD;
            pre_q      <= PREAMBLE << 1;
            sout       <= PREAMBLE[PRE_LEN-1];
            sout_valid <= 1'b1;
            ready      <= 1'b0;
            cnt_q      <= PreLast;
            state_q    <= StPre;
          end
        end
        StPre: begin
          if (cnt_q != '0) begin
            sout  <= pre_q[PRE_LEN-1];
            pre_q <= pre_q << 1;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            sout    <= data_q[DATA_W-1];
            data_q  <= data_q << 1;
            cnt_q   <= DataLast;
            state_q <= StData;
          end
        end
        StData: begin
          if (cnt_q != '0) begin
            sout   <= data_q[DATA_W-1];
            data_q <= data_q << 1;
            cnt_q  <= cnt_q - 1'b1;
          end else begin
            sout    <= par_q;
            done    <= 1'b1;
            state_q <= StPar;
          end
        end
        StPar: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
          cnt_q      <= GapLast;
          if (GAP > 0) begin
            state_q <= StGap;
          end else begin
            ready   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            ready   <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three parameterisations share stimulus; a frame-timing model
// checks every cycle, with vector tables and hand sequences for the corner cases.
module tb_serial_frame_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] ready_w, sout_w, valid_w, done_w;

  int checks   = 0;
  int failures = 0;

  // Per-instance parameters: 0 = defaults, 1 = odd parity, 2 = short frame with no gap.
  localparam int P_PRE [3] = '{4, 4, 2};
  localparam int P_DW  [3] = '{8, 8, 4};
  localparam int P_GAP [3] = '{2, 2, 0};
  localparam int P_ODD [3] = '{0, 1, 0};
  localparam int P_PRB [3] = '{10, 10, 2};

  serial_frame_tx dut0 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .ready(ready_w[0]), .sout(sout_w[0]), .sout_valid(valid_w[0]), .done(done_w[0])
  );

  serial_frame_tx #(.PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .ready(ready_w[1]), .sout(sout_w[1]), .sout_valid(valid_w[1]), .done(done_w[1])
  );

  serial_frame_tx #(.DATA_W(4), .PRE_LEN(2), .PREAMBLE(2'b10), .GAP(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in[3:0]),
    .ready(ready_w[2]), .sout(sout_w[2]), .sout_valid(valid_w[2]), .done(done_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic sout;
    logic valid;
    logic done;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_EXP = 4'b0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: remembers the accept cycle and captured data of each instance and derives
  // the output for any later cycle from the frame layout.
  int         cyc = 0;
  int         acc_cyc [3];
  logic [7:0] acc_dat [3];
  exp_t       cur [3];
  bit         mon_en = 1'b0;

  function automatic exp_t expect_at(input int k, input int c);
    exp_t e;
    int   t, pl, dw, fl;
    logic par;
    e = IDLE_EXP;
    if (acc_cyc[k] < 0) return e;
    t  = c - acc_cyc[k];
    pl = P_PRE[k];
    dw = P_DW[k];
    fl = pl + dw + 1;
    if (t >= fl + P_GAP[k]) return e;
    e = '0;
    if (t < fl) begin
      e.valid = 1'b1;
      if (t < pl) begin
        e.sout = ((P_PRB[k] >> (pl - 1 - t)) & 1) != 0;
      end else if (t < pl + dw) begin
        e.sout = acc_dat[k][dw - 1 - (t - pl)];
      end else begin
        par = (P_ODD[k] != 0);
        for (int i = 0; i < dw; i++) par ^= acc_dat[k][i];
        e.sout = par;
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      acc_cyc[k] = -1;
      acc_dat[k] = '0;
      cur[k]     = IDLE_EXP;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          acc_cyc[k] = -1;
        end else if (cur[k].ready && start) begin
          acc_cyc[k] = cyc;
          acc_dat[k] = data_in;
        end
        cur[k] = expect_at(k, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model dut%0d {sout,valid,done,ready}", k),
            {28'd0, sout_w[k], valid_w[k], done_w[k], ready_w[k]}, {28'd0, cur[k]});
      end
    end
  end

  typedef struct packed {
    logic [1:0] sel;
    logic       start;
    logic [7:0] data;
    exp_t       exp;
  } vec_t;

  vec_t tab [25];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t dut_out(input int k);
    return {sout_w[k], valid_w[k], done_w[k], ready_w[k]};
  endfunction

  task automatic run_tab(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      start   = tab[i].start;
      data_in = tab[i].data;
      step();
      chk($sformatf("vector %0d dut%0d", i, tab[i].sel),
          {28'd0, dut_out(int'(tab[i].sel))}, {28'd0, tab[i].exp});
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    start = 1'b0;
    n = 0;
    while (ready_w != 3'b111 && n < 200) begin
      step();
      n++;
    end
    chk("wait_idle all ready", {29'd0, ready_w}, 32'd7);
  endtask

  int rises [$];
  logic prev_v;

  initial begin
    // Defaults, data A5: preamble 1010, payload 10100101, even parity 0, two gap cycles.
    tab[0]  = '{2'd0, 1'b1, 8'hA5, 4'b1100};
    tab[1]  = '{2'd0, 1'b0, 8'hFF, 4'b0100};
    tab[2]  = '{2'd0, 1'b0, 8'h00, 4'b1100};
    tab[3]  = '{2'd0, 1'b0, 8'hFF, 4'b0100};
    tab[4]  = '{2'd0, 1'b0, 8'h00, 4'b1100};
    tab[5]  = '{2'd0, 1'b0, 8'hFF, 4'b0100};
    tab[6]  = '{2'd0, 1'b0, 8'h00, 4'b1100};
    tab[7]  = '{2'd0, 1'b0, 8'hFF, 4'b0100};
    tab[8]  = '{2'd0, 1'b0, 8'h00, 4'b0100};
    tab[9]  = '{2'd0, 1'b0, 8'hFF, 4'b1100};
    tab[10] = '{2'd0, 1'b0, 8'h00, 4'b0100};
    tab[11] = '{2'd0, 1'b0, 8'hFF, 4'b1100};
    tab[12] = '{2'd0, 1'b0, 8'h00, 4'b0110};
    tab[13] = '{2'd0, 1'b0, 8'hFF, 4'b0000};
    tab[14] = '{2'd0, 1'b0, 8'h00, 4'b0000};
    tab[15] = '{2'd0, 1'b0, 8'hFF, 4'b0001};
    // Short frame, no gap, data F: 10 1111 0, then an immediate restart.
    tab[16] = '{2'd2, 1'b1, 8'h0F, 4'b1100};
    tab[17] = '{2'd2, 1'b0, 8'h00, 4'b0100};
    tab[18] = '{2'd2, 1'b0, 8'h00, 4'b1100};
    tab[19] = '{2'd2, 1'b0, 8'h00, 4'b1100};
    tab[20] = '{2'd2, 1'b0, 8'h00, 4'b1100};
    tab[21] = '{2'd2, 1'b0, 8'h00, 4'b1100};
    tab[22] = '{2'd2, 1'b0, 8'h00, 4'b0110};
    tab[23] = '{2'd2, 1'b1, 8'h0F, 4'b0001};
    tab[24] = '{2'd2, 1'b1, 8'h0F, 4'b1100};

    reset   = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) chk($sformatf("reset dut%0d", k), {28'd0, dut_out(k)}, 32'd1);
    repeat (20) step();
    chk("idle after 20 cycles", {28'd0, dut_out(0)}, 32'd1);

    run_tab(0, 15);
    wait_idle();
    run_tab(16, 24);
    wait_idle();

    // Parity of 07: even gives 1, odd gives 0, both on the 13th frame cycle.
    start   = 1'b1;
    data_in = 8'h07;
    step();
    start   = 1'b0;
    data_in = 8'h00;
    repeat (12) step();
    chk("even parity of 07", {30'd0, sout_w[0], done_w[0]}, 32'd3);
    chk("odd parity of 07", {30'd0, sout_w[1], done_w[1]}, 32'd1);
    wait_idle();

    // Start held high with changing data: accepts every F+GAP+1 cycles.
    rises.delete();
    prev_v = valid_w[0];
    start  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = 8'($urandom);
      step();
      if (valid_w[0] && !prev_v) rises.push_back(i);
      prev_v = valid_w[0];
    end
    chk("held start accept count", rises.size(), 32'd3);
    if (rises.size() == 3) begin
      chk("accept spacing 1", rises[1] - rises[0], 32'd16);
      chk("accept spacing 2", rises[2] - rises[1], 32'd16);
    end
    wait_idle();

    // Reset during payload bit 3, then a clean frame.
    start   = 1'b1;
    data_in = 8'h3C;
    step();
    start = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort by reset", {28'd0, dut_out(0)}, 32'd1);
    start   = 1'b1;
    data_in = 8'hC3;
    step();
    chk("restart after reset", {28'd0, dut_out(0)}, 32'hC);
    wait_idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      step();
    end
    reset = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
